// File: rtl/nx_fifo_arb_pkg.sv
// Shared types and helpers for FIFO write arbiters: FSM state encoding,
// the burst ceiling and a round-robin pick function for up to 8 requesters.
package nx_fifo_arb_pkg;

   localparam int ARB_MAX_BURST = 15;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT    = 2'd1,
      CLR_WAIT = 2'd2,
      CLR      = 2'd3
   } arb_state_e;

   // First set bit of valid at or above ptr, wrapping at 8. Unused upper
   // bits must be zero, which makes the wrap equivalent to modulo N.
   function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr);
      logic [2:0] idx;
      logic [2:0] j;
      logic       found;
      idx   = ptr;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         j = ptr + 3'(i);
         if (!found && valid[j]) begin
            idx   = j;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/nx_rr_pick.sv
// Combinational round-robin picker: rotate-and-priority-encode of valid
// starting at ptr. Supports N up to 8.
module nx_rr_pick
   import nx_fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [2:0] pick;

   always_comb begin
      pick = rr_pick(8'(valid), 3'(ptr));
      idx  = IW'(pick);
      any  = |valid;
   end

endmodule

// File: rtl/nx_fifo_wr_arb.sv
// Burst-locked round-robin write arbiter in front of one nx_fifo write port,
// with free-slot throttling and a sequenced clear. NX_FIFO_WR_ARB_STATS_EN adds stall_cnt.
module nx_fifo_wr_arb
   import nx_fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 65,
   parameter int DEPTH = 2,
   parameter int BURST = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*WIDTH-1:0]     req_data,
   output logic [N_REQ-1:0]           req_ready,
   input  logic                       clear_req,
   output logic                       clear_done,
   output logic                       fifo_wen,
   output logic [WIDTH-1:0]           fifo_wdata,
   output logic                       fifo_clear,
   input  logic [$clog2(DEPTH+1)-1:0] fifo_free_slots,
`ifdef NX_FIFO_WR_ARB_STATS_EN
   output logic [15:0]                stall_cnt,
`endif
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy
);

   localparam int IW = $clog2(N_REQ);
   localparam int SW = $clog2(DEPTH+1);
   localparam int BW = $clog2(ARB_MAX_BURST+1);

   arb_state_e     state;
   logic [IW-1:0]  rr_ptr;
   logic [IW-1:0]  pick_idx;
   logic [IW-1:0]  next_ptr;
   logic [BW-1:0]  beat_cnt;
   logic           clr_pend;
   logic           pick_any;
   logic           space;
   logic           own_valid;
   logic           accept;
   logic           last_beat;
   logic           burst_end;
   logic           clr_seen;
   logic [WIDTH-1:0] own_data;

   nx_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      own_valid = 1'b0;
      own_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == IW'(i)) begin
            own_valid = req_valid[i];
            own_data  = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // A registered write still in flight is not yet reflected in free_slots.
   assign space     = fifo_free_slots > SW'(fifo_wen);
   assign accept    = (state == GRANT) && own_valid && space;
   assign last_beat = accept && (beat_cnt == BW'(BURST-1));
   assign burst_end = (state == GRANT) && (last_beat || !own_valid);
   assign clr_seen  = clr_pend | clear_req;
   assign next_ptr  = (grant_id == IW'(N_REQ-1)) ? '0 : grant_id + IW'(1);
   assign busy      = (state == GRANT);

   // Handshake: a beat moves on a cycle where req_valid[i] & req_ready[i];
   // ready depends only on state, grant_id and free slots, never on valid.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++)
         req_ready[i] = (state == GRANT) && (grant_id == IW'(i)) && space;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant_id   <= '0;
         rr_ptr     <= '0;
         beat_cnt   <= '0;
         clr_pend   <= 1'b0;
         fifo_wen   <= 1'b0;
         fifo_wdata <= '0;
         fifo_clear <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         fifo_wen   <= accept;
         fifo_clear <= 1'b0;
         clear_done <= 1'b0;
         clr_pend   <= clr_seen;
         if (accept)
            fifo_wdata <= own_data;
         case (state)
            IDLE: begin
               if (clr_seen) begin
                  state <= CLR_WAIT;
               end else if (pick_any) begin
                  grant_id <= pick_idx;
                  beat_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (accept)
                  beat_cnt <= beat_cnt + BW'(1);
               if (burst_end) begin
                  rr_ptr <= next_ptr;
                  state  <= clr_seen ? CLR_WAIT : IDLE;
               end
            end
            CLR_WAIT: begin
               fifo_clear <= 1'b1;
               clear_done <= 1'b1;
               state      <= CLR;
            end
            CLR: begin
               clr_pend <= clear_req;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef NX_FIFO_WR_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (fifo_clear)
         stall_cnt <= '0;
      else if ((state == GRANT) && own_valid && !space && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule
